// File: rtl/icache_direct.sv
// icache_direct: direct-mapped read-only instruction cache with single-line refill; optional ICACHE_STATS_EN hit/miss counters
package brisc_pkg;
  localparam int ILEN = 32;
  localparam int ADDRESS_BITS = 32;
endpackage

module icache_direct
  import brisc_pkg::*;
#(
  parameter int NUM_LINES  = 4,
  parameter int LINE_BYTES = 16,
  parameter int LINE_BITS  = LINE_BYTES * 8
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [ADDRESS_BITS-1:0] pc,
  input  logic                    fetch_valid,
  input  logic                    flush,
  output logic [ILEN-1:0]         instr,
  output logic                    hit,
  output logic                    icache_stall,
  output logic                    mem_req,
  output logic [ADDRESS_BITS-1:0] mem_addr,
  input  logic                    mem_resp,
  input  logic [LINE_BITS-1:0]    mem_data
`ifdef ICACHE_STATS_EN
  ,
  output logic [31:0]             stat_hits,
  output logic [31:0]             stat_misses
`endif
);
  localparam int OFF  = $clog2(LINE_BYTES);
  localparam int IDX  = $clog2(NUM_LINES);
  localparam int TAGW = ADDRESS_BITS - OFF - IDX;
  localparam int WB   = (OFF > 2) ? OFF - 2 : 1;
  typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;
  state_t                  r_state, w_next;
  logic [LINE_BITS-1:0]    r_data [NUM_LINES];
  logic [TAGW-1:0]         r_tag  [NUM_LINES];
  logic [NUM_LINES-1:0]    r_valid;
  logic [ADDRESS_BITS-1:0] r_addr;
  logic                    r_flushed;
  logic [IDX-1:0]          w_idx, w_fidx;
  logic [TAGW-1:0]         w_tag;
  logic [WB-1:0]           w_word;
  logic                    w_fill, w_miss, w_unused;
  assign w_idx    = pc[OFF+IDX-1:OFF];
  assign w_tag    = pc[ADDRESS_BITS-1:OFF+IDX];
  assign w_word   = (LINE_BYTES == 4) ? '0 : WB'(pc[ADDRESS_BITS-1:2]);
  assign w_fidx   = r_addr[OFF+IDX-1:OFF];
  assign w_fill   = r_state == WAIT && mem_resp;
  assign w_unused = ^pc[1:0];
  // Lookup, stall and memory handshake outputs
  always_comb begin
    hit          = fetch_valid && r_state == IDLE && r_valid[w_idx] && r_tag[w_idx] == w_tag;
    instr        = hit ? r_data[w_idx][ILEN*w_word +: ILEN] : '0;
    w_miss       = fetch_valid && r_state == IDLE && !hit;
    icache_stall = r_state != IDLE || w_miss;
    mem_req      = r_state == REQ || (r_state == WAIT && !mem_resp);
    mem_addr     = r_addr;
    w_next       = r_state == IDLE ? (w_miss ? REQ : IDLE) : r_state == REQ ? WAIT : (mem_resp ? IDLE : WAIT);
  end
  // State, refill address, valid bits; a flush during refill keeps the filled line invalid
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= IDLE;
      r_addr    <= '0;
      r_flushed <= 1'b0;
      r_valid   <= '0;
    end else begin
      r_state <= w_next;
      if (w_miss) r_addr <= {pc[ADDRESS_BITS-1:OFF], {OFF{1'b0}}};
      r_flushed <= r_state != IDLE && (flush || r_flushed);
      if (flush) r_valid <= '0;
      else if (w_fill && !r_flushed) r_valid[w_fidx] <= 1'b1;
    end
  end
  // Line data and tag storage, written only on the refill response
  always_ff @(posedge clk) begin
    if (w_fill) begin
      r_data[w_fidx] <= mem_data;
      r_tag[w_fidx]  <= r_addr[ADDRESS_BITS-1:OFF+IDX];
    end
  end
`ifdef ICACHE_STATS_EN
  logic [31:0] r_hits, r_misses;
  // Hit and miss counters, cleared only by reset
  always_ff @(posedge clk) begin
    if (reset) begin
      r_hits   <= '0;
      r_misses <= '0;
    end else begin
      if (hit) r_hits <= r_hits + 32'd1;
      if (w_miss) r_misses <= r_misses + 32'd1;
    end
  end
  assign stat_hits   = r_hits;
  assign stat_misses = r_misses;
`endif
endmodule

// File: tb/tb_icache_direct.sv
// tb_icache_direct: directed self-checking bench for icache_direct
module tb_icache_direct;
  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic [31:0]  pc = '0;
  logic         fetch_valid = 1'b0;
  logic         flush = 1'b0;
  logic [31:0]  instr;
  logic         hit, icache_stall, mem_req;
  logic [31:0]  mem_addr;
  logic         mem_resp = 1'b0;
  logic [127:0] mem_data = '0;
  int checks = 0;
  int errors = 0;
`ifdef ICACHE_STATS_EN
  logic [31:0] stat_hits, stat_misses;
`endif
  icache_direct dut (
    .clk(clk), .reset(reset), .pc(pc), .fetch_valid(fetch_valid), .flush(flush),
    .instr(instr), .hit(hit), .icache_stall(icache_stall), .mem_req(mem_req),
    .mem_addr(mem_addr), .mem_resp(mem_resp), .mem_data(mem_data)
`ifdef ICACHE_STATS_EN
    , .stat_hits(stat_hits), .stat_misses(stat_misses)
`endif
  );
  always #5 clk = ~clk;

  function automatic logic [31:0] word_of(input logic [31:0] a);
    return (a & 32'hFFFF_FFFC) ^ 32'hA5C3_0000;
  endfunction
  function automatic logic [127:0] line_of(input logic [31:0] a);
    logic [31:0] b;
    b = a & 32'hFFFF_FFF0;
    return {word_of(b + 12), word_of(b + 8), word_of(b + 4), word_of(b)};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic refill(input logic [31:0] a);
    pc = a; fetch_valid = 1'b1;
    #1;
    checks++; if (icache_stall !== 1'b1 || hit !== 1'b0) begin errors++; $display("FAIL miss_%h: stall=%b hit=%b want stall=1 hit=0", a, icache_stall, hit); end
    tick();
    checks++; if (mem_req !== 1'b1 || mem_addr !== (a & 32'hFFFF_FFF0)) begin errors++; $display("FAIL req_%h: req=%b addr=%h want 1 %h", a, mem_req, mem_addr, a & 32'hFFFF_FFF0); end
    tick();
    checks++; if (mem_req !== 1'b1 || icache_stall !== 1'b1) begin errors++; $display("FAIL wait_%h: req=%b stall=%b want 1 1", a, mem_req, icache_stall); end
    tick();
    mem_resp = 1'b1; mem_data = line_of(a);
    #1;
    checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL req_drop_%h: req=%b want 0", a, mem_req); end
    tick();
    mem_resp = 1'b0;
    #1;
    checks++; if (hit !== 1'b1 || instr !== word_of(a) || icache_stall !== 1'b0) begin errors++; $display("FAIL fill_hit_%h: hit=%b instr=%h stall=%b want 1 %h 0", a, hit, instr, icache_stall, word_of(a)); end
  endtask

  task automatic test_reset();
    reset = 1'b1; fetch_valid = 1'b0; flush = 1'b0; mem_resp = 1'b0;
    tick(); tick();
    reset = 1'b0;
    #1;
    checks++; if ({hit, icache_stall, mem_req} !== 3'b000 || mem_addr !== 32'h0 || instr !== 32'h0) begin errors++; $display("FAIL reset: hit/stall/req=%b addr=%h instr=%h want 000 0 0", {hit, icache_stall, mem_req}, mem_addr, instr); end
  endtask

  task automatic test_cold_miss();
    tick();
    refill(32'h100);
  endtask

  task automatic test_same_line();
    logic [31:0] a;
    for (int i = 1; i < 4; i++) begin
      tick();
      a = 32'h100 + 32'(4 * i);
      pc = a;
      #1;
      checks++; if (hit !== 1'b1 || instr !== word_of(a) || mem_req !== 1'b0 || icache_stall !== 1'b0) begin errors++; $display("FAIL same_line_%h: hit=%b instr=%h req=%b stall=%b want 1 %h 0 0", a, hit, instr, mem_req, icache_stall, word_of(a)); end
    end
  endtask

  task automatic test_stats();
`ifdef ICACHE_STATS_EN
    tick();
    fetch_valid = 1'b0;
    #1;
    checks++; if (stat_misses !== 32'd1 || stat_hits !== 32'd4) begin errors++; $display("FAIL stats: misses=%0d hits=%0d want 1 4", stat_misses, stat_hits); end
`endif
  endtask

  task automatic test_no_fetch();
    tick();
    fetch_valid = 1'b0; pc = 32'h500;
    #1;
    checks++; if ({hit, icache_stall} !== 2'b00 || instr !== 32'h0) begin errors++; $display("FAIL no_fetch: hit/stall=%b instr=%h want 00 0", {hit, icache_stall}, instr); end
    tick();
    checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL no_fetch_req: req=%b want 0", mem_req); end
  endtask

  task automatic test_conflict();
    tick();
    refill(32'h140);
    tick();
    refill(32'h100);
  endtask

  task automatic test_flush_wait();
    tick();
    pc = 32'h200; fetch_valid = 1'b1;
    tick(); tick();
    flush = 1'b1;
    #1;
    checks++; if (mem_req !== 1'b1) begin errors++; $display("FAIL flush_wait_req: req=%b want 1", mem_req); end
    tick();
    flush = 1'b0; mem_resp = 1'b1; mem_data = line_of(32'h200);
    tick();
    mem_resp = 1'b0;
    #1;
    checks++; if ({hit, icache_stall, mem_req} !== 3'b010) begin errors++; $display("FAIL flush_remiss: hit/stall/req=%b want 010", {hit, icache_stall, mem_req}); end
    tick();
    checks++; if (mem_req !== 1'b1 || mem_addr !== 32'h200) begin errors++; $display("FAIL flush_rereq: req=%b addr=%h want 1 200", mem_req, mem_addr); end
    tick();
    mem_resp = 1'b1; mem_data = line_of(32'h200);
    tick();
    mem_resp = 1'b0;
    #1;
    checks++; if (hit !== 1'b1 || instr !== word_of(32'h200)) begin errors++; $display("FAIL flush_refill: hit=%b instr=%h want 1 %h", hit, instr, word_of(32'h200)); end
    tick();
    pc = 32'h100;
    #1;
    checks++; if (hit !== 1'b0) begin errors++; $display("FAIL flush_cleared_100: hit=%b want 0", hit); end
    fetch_valid = 1'b0;
  endtask

  task automatic test_resp_in_req();
    tick();
    pc = 32'h400; fetch_valid = 1'b1;
    tick();
    mem_resp = 1'b1; mem_data = {4{32'hDEAD_BEEF}};
    tick();
    mem_resp = 1'b0;
    #1;
    checks++; if (mem_req !== 1'b1 || hit !== 1'b0) begin errors++; $display("FAIL resp_in_req: req=%b hit=%b want 1 0", mem_req, hit); end
    mem_resp = 1'b1; mem_data = line_of(32'h400);
    tick();
    mem_resp = 1'b0;
    #1;
    checks++; if (hit !== 1'b1 || instr !== word_of(32'h400)) begin errors++; $display("FAIL resp_after_req: hit=%b instr=%h want 1 %h", hit, instr, word_of(32'h400)); end
  endtask

  task automatic test_flush_idle();
    tick();
    pc = 32'h40C; fetch_valid = 1'b1; flush = 1'b1;
    #1;
    checks++; if (hit !== 1'b1 || instr !== word_of(32'h40C)) begin errors++; $display("FAIL pre_flush_hit: hit=%b instr=%h want 1 %h", hit, instr, word_of(32'h40C)); end
    tick();
    flush = 1'b0;
    #1;
    checks++; if (hit !== 1'b0 || icache_stall !== 1'b1) begin errors++; $display("FAIL flush_idle: hit=%b stall=%b want 0 1", hit, icache_stall); end
    fetch_valid = 1'b0;
  endtask

  task automatic test_reset_wait();
    tick();
    refill(32'h100);
    tick();
    pc = 32'h300; fetch_valid = 1'b1;
    tick(); tick();
    reset = 1'b1; fetch_valid = 1'b0;
    tick();
    reset = 1'b0;
    #1;
    checks++; if ({hit, icache_stall, mem_req} !== 3'b000 || mem_addr !== 32'h0) begin errors++; $display("FAIL reset_wait: hit/stall/req=%b addr=%h want 000 0", {hit, icache_stall, mem_req}, mem_addr); end
    mem_resp = 1'b1; mem_data = line_of(32'h300);
    tick();
    mem_resp = 1'b0;
    #1;
    checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL late_resp_req: req=%b want 0", mem_req); end
    pc = 32'h300; fetch_valid = 1'b1;
    #1;
    checks++; if (hit !== 1'b0) begin errors++; $display("FAIL late_resp_300: hit=%b want 0", hit); end
    pc = 32'h100;
    #1;
    checks++; if (hit !== 1'b0 || icache_stall !== 1'b1) begin errors++; $display("FAIL reset_100_miss: hit=%b stall=%b want 0 1", hit, icache_stall); end
    fetch_valid = 1'b0;
  endtask

  initial begin
    test_reset();
    test_cold_miss();
    test_same_line();
    test_stats();
    test_no_fetch();
    test_conflict();
    test_flush_wait();
    test_resp_in_req();
    test_flush_idle();
    test_reset_wait();
    tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
